// File: rtl/trace_beat_serializer_if.sv
// Handshake bundle between the trace FIFO, trace_beat_serializer and the host link.
// The master side is the serializer. The slave side is the FIFO plus the link.
interface trace_beat_serializer_if;
  logic         rec_valid;
  logic         rec_ready;
  logic [511:0] rec_data;
  logic [6:0]   rec_size;
  logic         beat_valid;
  logic         beat_ready;
  logic [63:0]  beat_data;
  logic         beat_last;

  modport master (
    input  rec_valid, rec_data, rec_size, beat_ready,
    output rec_ready, beat_valid, beat_data, beat_last
  );

  modport slave (
    output rec_valid, rec_data, rec_size, beat_ready,
    input  rec_ready, beat_valid, beat_data, beat_last
  );
endinterface

// File: rtl/trace_beat_serializer.sv
// Splits 48/64-byte trace records into 64-bit beats for the host link. Malformed records are dropped and counted.
// Optional TRACE_SER_STALL_STATS_EN adds a stall_cycles counter for cycles where a beat waits on the link.
module trace_beat_serializer #(
  parameter bit CHECK_VERSION = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  trace_beat_serializer_if.master bus,
  output logic [31:0]             rec_count,
  output logic [31:0]             err_count
`ifdef TRACE_SER_STALL_STATS_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [6:0] SIZE_V11 = 7'd48;
  localparam logic [6:0] SIZE_V12 = 7'd64;
  localparam logic [7:0] VER_V11  = 8'h01;
  localparam logic [7:0] VER_V12  = 8'h02;

  state_e         state_q, state_d;
  logic [511:0]   holding_q;
  logic [3:0]     beats_total_q;
  logic [2:0]     beat_idx_q, beat_idx_d;

  logic rec_legal;
  logic rec_fire;
  logic beat_fire;
  logic at_last;
  logic load;
  logic rec_inc;
  logic err_inc;

  always_comb begin
    rec_legal = 1'b0;
    if (bus.rec_size == SIZE_V11) begin
      rec_legal = !CHECK_VERSION || (bus.rec_data[7:0] == VER_V11);
    end else if (bus.rec_size == SIZE_V12) begin
      rec_legal = !CHECK_VERSION || (bus.rec_data[7:0] == VER_V12);
    end
  end

  assign at_last = ({1'b0, beat_idx_q} == (beats_total_q - 4'd1));

  assign bus.beat_valid = (state_q == SEND);
  assign bus.beat_last  = (state_q == SEND) && at_last;
  assign bus.beat_data  = holding_q[{beat_idx_q, 6'd0} +: 64];

  // A new record is taken in the same cycle as the final beat. This keeps back-to-back records bubble-free.
  assign bus.rec_ready = !rst && ((state_q == IDLE) || (at_last && bus.beat_ready));

  assign beat_fire = bus.beat_valid && bus.beat_ready;
  assign rec_fire  = bus.rec_valid && bus.rec_ready;

  // The beat handshake is resolved first, and a record accepted in the same cycle overrides it.
  // rec_fire can only be set in IDLE or during a last-beat handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    load       = 1'b0;
    rec_inc    = 1'b0;
    err_inc    = 1'b0;

    if (beat_fire) begin
      if (at_last) begin
        rec_inc = 1'b1;
        state_d = IDLE;
      end else begin
        beat_idx_d = beat_idx_q + 3'd1;
      end
    end

    if (rec_fire) begin
      if (rec_legal) begin
        load       = 1'b1;
        state_d    = SEND;
        beat_idx_d = '0;
      end else begin
        err_inc = 1'b1;
      end
    end
  end

  // NOTE: all state updates are non-blocking, so every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_idx_q    <= '0;
      beats_total_q <= '0;
      // NOTE: the holding register is reset on purpose. beat_data must read 0 coming out of reset.
      holding_q     <= '0;
      rec_count     <= '0;
      err_count     <= '0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      if (load) begin
        holding_q     <= bus.rec_data;
        beats_total_q <= bus.rec_size[6:3];
      end
      if (rec_inc) begin
        rec_count <= rec_count + 32'd1;
      end
      if (err_inc) begin
        err_count <= err_count + 32'd1;
      end
    end
  end

`ifdef TRACE_SER_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.beat_valid && !bus.beat_ready) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  // This build has no stall statistics.
`endif

endmodule

// File: tb/tb_trace_beat_serializer.sv
// Self-checking bench for trace_beat_serializer. A scoreboard of expected beats is fed when each record is accepted.
// Define TRACE_SER_STALL_STATS_EN to also check stall_cycles.
module tb_trace_beat_serializer;

  typedef struct {
    logic [7:0] ver;
    logic [6:0] size;
    bit         exp_legal;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rec_count;
  logic [31:0] err_count;
`ifdef TRACE_SER_STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  trace_beat_serializer_if bus();

  trace_beat_serializer #(.CHECK_VERSION(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rec_count (rec_count),
    .err_count (err_count)
`ifdef TRACE_SER_STALL_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int    tests_run    = 0;
  int    tests_failed = 0;
  beat_t sb[$];
  int    cyc            = 0;
  int    fire_count     = 0;
  int    first_fire_cyc = -1;
  int    last_fire_cyc  = -1;
  int    accept_cyc     = -1;
  bit    arm            = 1'b0;
  int    exp_rec        = 0;
  int    exp_err        = 0;
  vec_t  vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Beat monitor. It samples late in the low phase, after all stimulus for that cycle has settled.
  initial begin : monitor
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    beat_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (prev_stall && !rst) begin
        check("stall_hold_valid", bus.beat_valid, 1);
        check("stall_hold_data", bus.beat_data, prev_data);
        check("stall_hold_last", bus.beat_last, prev_last);
      end
      if (!bus.beat_valid) begin
        check("last_low_when_idle", bus.beat_last, 0);
      end
      if (bus.beat_valid && bus.beat_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", bus.beat_data);
        end else begin
          e = sb.pop_front();
          check("beat_data", bus.beat_data, e.data);
          check("beat_last", bus.beat_last, e.last);
        end
        fire_count++;
        last_fire_cyc = cyc;
        if (arm) begin
          first_fire_cyc = cyc;
          arm = 1'b0;
        end
      end
      prev_stall = bus.beat_valid && !bus.beat_ready;
      prev_data  = bus.beat_data;
      prev_last  = bus.beat_last;
    end
  end

  // The caller must be at a negedge. The task returns at the negedge after acceptance, with rec_valid low.
  task automatic send_record(input logic [7:0] ver, input logic [6:0] size,
                             input logic [63:0] base, input bit exp_legal);
    logic [511:0] d;
    int           n;
    bit           got;
    beat_t        b;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = base + 64'(k);
    d[7:0] = ver;
    bus.rec_data  = d;
    bus.rec_size  = size;
    bus.rec_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (bus.rec_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL rec_accept_timeout: rec_ready never rose, expected acceptance");
    end else begin
      accept_cyc = cyc;
      if (exp_legal) begin
        n = int'(size) / 8;
        for (int k = 0; k < n; k++) begin
          b.data = d[64*k +: 64];
          b.last = (k == n - 1);
          sb.push_back(b);
        end
        exp_rec++;
      end else begin
        exp_err++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.rec_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !bus.beat_valid) begin
        done = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_drain_timeout: %0d beats still pending, expected 0", name, sb.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    bit got;

    vecs = '{
      '{ver: 8'h00, size: 7'd40, exp_legal: 1'b0},
      '{ver: 8'h01, size: 7'd64, exp_legal: 1'b0},
      '{ver: 8'h02, size: 7'd48, exp_legal: 1'b0},
      '{ver: 8'h02, size: 7'd56, exp_legal: 1'b0},
      '{ver: 8'h01, size: 7'd48, exp_legal: 1'b1},
      '{ver: 8'h02, size: 7'd64, exp_legal: 1'b1}
    };

    bus.rec_valid  = 1'b0;
    bus.rec_data   = '0;
    bus.rec_size   = '0;
    bus.beat_ready = 1'b1;
    rst            = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rec_ready_in_reset", bus.rec_ready, 0);
    check("beat_valid_reset", bus.beat_valid, 0);
    check("beat_last_reset", bus.beat_last, 0);
    check("beat_data_reset", bus.beat_data, 0);
    check("rec_count_reset", rec_count, 0);
    check("err_count_reset", err_count, 0);
`ifdef TRACE_SER_STALL_STATS_EN
    check("stall_cycles_reset", stall_cycles, 0);
`else
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rec_ready_idle", bus.rec_ready, 1);

    // One v1.2 record with the link always ready
    @(negedge clk);
    arm = 1'b1;
    send_record(8'h02, 7'd64, 64'h1000, 1'b1);
    drain("v12_single");
    check("v12_first_beat_latency", 64'(first_fire_cyc - accept_cyc), 1);
    check("v12_beats_contiguous", 64'(last_fire_cyc - first_fire_cyc), 7);
    check("v12_rec_count", rec_count, 1);
    check("v12_err_count", err_count, 0);

    // Two v1.1 records back to back, with no bubble between them
    @(negedge clk);
    arm = 1'b1;
    send_record(8'h01, 7'd48, 64'h2000, 1'b1);
    send_record(8'h01, 7'd48, 64'h3000, 1'b1);
    drain("v11_pair");
    check("v11_pair_contiguous", 64'(last_fire_cyc - first_fire_cyc), 11);
    check("v11_pair_rec_count", rec_count, 3);

    // Legality sweep
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      send_record(vecs[i].ver, vecs[i].size, 64'h7000 + 64'(i) * 64'h100, vecs[i].exp_legal);
      #1;
      check($sformatf("vec%0d_rec_ready", i), bus.rec_ready, vecs[i].exp_legal ? 0 : 1);
      check($sformatf("vec%0d_beat_valid", i), bus.beat_valid, vecs[i].exp_legal);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_err_count", i), err_count, 64'(exp_err));
      check($sformatf("vec%0d_rec_count", i), rec_count, 64'(exp_rec));
    end

    // Reset after the third beat of a v1.2 record
    @(negedge clk);
    send_record(8'h02, 7'd64, 64'h4000, 1'b1);
    base = fire_count;
    got  = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #3;
      if (fire_count - base >= 3) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL reset_wait_3_beats: saw %0d beats, expected 3", fire_count - base);
    end
    rst = 1'b1;
    #1;
    check("rec_ready_during_rst", bus.rec_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_rec = 0;
    exp_err = 0;
    #3;
    check("midrec_rst_beat_valid", bus.beat_valid, 0);
    check("midrec_rst_beat_last", bus.beat_last, 0);
    check("midrec_rst_beat_data", bus.beat_data, 0);
    check("midrec_rst_rec_count", rec_count, 0);
    check("midrec_rst_err_count", err_count, 0);
    base = fire_count;
    repeat (5) @(negedge clk);
    check("midrec_no_leftover_beats", 64'(fire_count - base), 0);
    arm = 1'b1;
    send_record(8'h02, 7'd64, 64'h5000, 1'b1);
    drain("post_reset");
    check("post_reset_latency", 64'(first_fire_cyc - accept_cyc), 1);
    check("post_reset_rec_count", rec_count, 1);

    // v1.2 record with beat_ready toggling 1,0,1,0,...
    @(negedge clk);
    base = fire_count;
    send_record(8'h02, 7'd64, 64'h6000, 1'b1);
    for (int i = 0; i < 15; i++) begin
      bus.beat_ready = (i % 2 == 0);
      @(negedge clk);
    end
    bus.beat_ready = 1'b1;
    drain("stall_toggle");
    check("stall_toggle_beats", 64'(fire_count - base), 8);
    check("stall_toggle_rec_count", rec_count, 2);
`ifdef TRACE_SER_STALL_STATS_EN
    check("stall_cycles_count", stall_cycles, 7);
`else
`endif

    // rec_count wraps from 0xFFFFFFFF to 0
    @(negedge clk);
    force dut.rec_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.rec_count;
    send_record(8'h02, 7'd64, 64'h8000, 1'b1);
    drain("wrap");
    check("rec_count_wrap", rec_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trace_beat_serializer.md
TRACE_BEAT_SERIALIZER -- requirements
Module: trace_beat_serializer

Interface
REQ-001 Parameter CHECK_VERSION, default 1: validate version byte against record size.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rec_valid  in  1  trace record offered by the upstream trace FIFO.
REQ-005 rec_ready  out  1  record accepted when rec_valid && rec_ready.
REQ-006 rec_data  in  512  trace record; byte 0 = rec_data[7:0] = version.
REQ-007 rec_size  in  7  record length in bytes; legal values 48 (v1.1) and 64 (v1.2).
REQ-008 beat_valid  out  1  64-bit beat available to the host link.
REQ-009 beat_ready  in  1  beat consumed when beat_valid && beat_ready.
REQ-010 beat_data  out  64  current beat.
REQ-011 beat_last  out  1  marks the final beat of a record.
REQ-012 rec_count  out  32  records fully emitted.
REQ-013 err_count  out  32  records dropped as malformed.

Function
REQ-014 FSM states: IDLE and SEND.
REQ-015 In IDLE, rec_ready SHALL be 1 and beat_valid 0.
REQ-016 On acceptance of a legal record: latch rec_data into a 512-bit holding register; set beats_total = rec_size/8 (6 or 8); set beat_idx = 0; enter SEND on the next cycle.
REQ-017 Legality: rec_size must be 48 or 64. When CHECK_VERSION=1, the version byte must also match the size (0x01 with 48, 0x02 with 64).
REQ-018 An illegal record SHALL be accepted in one cycle and not emitted. err_count increments by 1 and the FSM stays in IDLE.
REQ-019 In SEND, beat_valid SHALL be 1 and beat_data SHALL equal holding[64*beat_idx +: 64].
REQ-020 beat_last SHALL equal (beat_idx == beats_total-1) while beat_valid=1, and 0 otherwise.
REQ-021 beat_data, beat_last and beat_valid SHALL hold stable while beat_valid && !beat_ready.
REQ-022 On a beat handshake that is not last, beat_idx increments by 1.
REQ-023 On a last-beat handshake, rec_count increments by 1 and the FSM returns to IDLE.
REQ-024 rec_ready SHALL also be 1 in SEND during a last-beat handshake (combinational from beat_ready). A record accepted in that cycle is loaded directly, keeping SEND with beat_idx=0, so back-to-back records have zero bubble cycles.
REQ-025 In SEND, rec_ready SHALL be 0 at all other times.
REQ-026 Latency: the first beat is valid on the cycle after record acceptance.
REQ-027 Throughput: one beat per cycle with beat_ready held high, i.e. 8 cycles per v1.2 record and 6 per v1.1.
REQ-028 Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-029 An illegal record accepted during a last-beat handshake increments err_count and the FSM goes to IDLE.

Reset
REQ-030 While rst=1 at a clock edge: FSM=IDLE, beat_idx=0, holding register=0, beat_valid=0, beat_last=0, beat_data=0, rec_count=0, err_count=0.
REQ-031 rec_ready SHALL be 0 while rst is asserted.
REQ-032 Reset mid-record SHALL discard the partial record. No further beats of it are emitted after rst deasserts, and rec_count is not incremented for it.

Configuration
REQ-033 Macro TRACE_SER_STALL_STATS_EN adds output stall_cycles [31:0]. It is reset to 0 and increments (wrapping) on every cycle with beat_valid && !beat_ready.
REQ-034 Without TRACE_SER_STALL_STATS_EN, the stall_cycles port and its counter SHALL be absent. All other behaviour is identical.

Verification
REQ-035 One v1.2 record (version 0x02, size 64, data words 0..7 = 0x1000+k), beat_ready=1 -> 8 beats 0x1000..0x1007 on consecutive cycles, beat_last only on the 8th, rec_count=1.
REQ-036 Two v1.1 records back-to-back (size 48), beat_ready=1 -> 12 contiguous beats, beat_last on beats 6 and 12, no idle cycle between records, rec_count=2.
REQ-037 v1.2 record with beat_ready toggling 1,0,1,0 -> each beat stable during stalls, 8 beats total, stall_cycles=7 when the macro is defined.
REQ-038 Records with size 40, then (CHECK_VERSION=1) version 0x01 with size 64 -> both dropped, err_count=2, no beats emitted, rec_ready stays 1.
REQ-039 rst asserted for 1 cycle after the 3rd beat of a v1.2 record -> beat_valid=0 after reset, counters=0, the next record emits cleanly from beat 0.
REQ-040 Counter wrap: rec_count forced/preloaded to 0xFFFFFFFF, one record emitted -> rec_count=0.
